onehot_decode_pulser: RTL and testbench
=======================================

// Module: onehot_decode_pulser
// PURPOSE
//  Inverse of the priority encoder path: accepts (code, nonzero-flag) pairs and drives them out as
//  one-hot lines, each held for HOLD cycles.
//  Pairs arrive on a valid/ready stream, are queued in a small FIFO, then replayed one after another.
//  Sits between the encoder/arbiter stage and downstream select/enable lines that need a stable one-hot.
// PARAMETERS
//  CW     2   code width; OUT_Y is 2**CW bits wide
//  HOLD   4   cycles each decoded word stays on OUT_Y (>=1)
//  DEPTH  2   FIFO entries (power of two, >=2)
// PORTS
//  CLK       in   1        single clock, rising edge
//  RST       in   1        asynchronous, active-high reset
//  IN_VALID  in   1        IN_CODE/IN_NZ valid
//  IN_READY  out  1        block can accept; transfer when IN_VALID&&IN_READY at CLK edge
//  IN_CODE   in   CW       encoded index (2'b11 = bit 3 ... 2'b00 = bit 0 for CW=2)
//  IN_NZ     in   1        1 = some input bit was set; 0 = "no request"
//  OUT_Y     out  2**CW    decoded word: 1<<IN_CODE if IN_NZ, else all-zero
//  OUT_BUSY  out  1        1 while a word is being held (state DRIVE)
//  DONE      out  1        1-cycle pulse on the last hold cycle of each word
// BEHAVIOUR
//  Reset (async, RST=1): FIFO empty, state IDLE, counter 0, OUT_Y=0, OUT_BUSY=0, DONE=0.
//   IN_READY=1 once RST deasserts.
//  Input side:
//   - IN_READY = !full. Registered from FIFO state; never depends on IN_VALID.
//   - Full and popping in the same cycle: still not ready (no push-through).
//   - Accepted pair is written at the edge of the handshake.
//  FSM states IDLE, DRIVE:
//   - IDLE: if FIFO non-empty then pop, load OUT_Y=decode(entry), cnt=HOLD-1, go DRIVE.
//     Otherwise OUT_Y=0.
//   - DRIVE: OUT_BUSY=1, OUT_Y stable.
//     If cnt!=0 then cnt--.
//     If cnt==0 then DONE=1 this cycle and:
//       FIFO non-empty: pop and reload next word at this edge (back-to-back, no gap cycle).
//       FIFO empty: go IDLE, OUT_Y=0 from the next cycle.
//  Latency: pair accepted at edge t appears on OUT_Y after edge t+1, when the FSM is idle.
//   Each word occupies exactly HOLD cycles on OUT_Y.
//  IN_NZ=0 entry: OUT_Y=0 for HOLD cycles with OUT_BUSY=1 and a DONE pulse.
//   This preserves stream timing.
//  OUT_Y, OUT_BUSY and DONE are all registered; no combinational path from inputs to outputs.
//  Simultaneous push and pop with FIFO non-full: both occur; count unchanged.
//  Pointers wrap modulo DEPTH.
//  RST mid-hold: OUT_Y is cleared immediately and queued entries are discarded.
//  HOLD=1: one word per cycle, DONE high every DRIVE cycle.
// STRUCTURE
//  Package decode_pkg:
//   - typedef enum logic {IDLE,DRIVE} state_t
//   - function onehot(code,nz) returning the 2**CW word
//   - localparam CNT_W = $clog2(HOLD+1)
//  Sub-module code_fifo (width CW+1, depth DEPTH):
//   - ports push/pop/full/empty/dout
//   - asynchronous active-high reset
//  Top: FSM + hold counter + output registers.
// TESTING (CW=2, HOLD=4, DEPTH=2)
//  1. RST pulse mid-run -> OUT_Y=0, OUT_BUSY=0, DONE=0 immediately; IN_READY=1 after release.
//  2. One push code=2'b10 nz=1 at edge t ->
//     OUT_Y=4'b0100 for cycles t+2..t+5, DONE at t+5, OUT_Y=0 at t+6.
//  3. Three pushes (11,01,00, nz=1) on consecutive cycles ->
//     IN_READY drops once 2 entries are queued;
//     OUT_Y=1000,0010,0001 back-to-back, 4 cycles each, no gap; 3 DONE pulses.
//  4. Push code=2'b11 nz=0 -> OUT_Y=0000 with OUT_BUSY=1 for 4 cycles, one DONE pulse.
//  5. Hold IN_VALID=1 continuously with random codes -> every accepted pair appears once, in order.
//     Scoreboard vs reference queue; no loss when full.
//  6. RST asserted during cycle 2 of a hold with 1 queued entry ->
//     OUT_Y=0 at once; queued entry never appears after reset release.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and defaults for the one-hot decode pulser.
package decode_pkg;

    localparam int unsigned DEF_CW    = 2;
    localparam int unsigned DEF_HOLD  = 4;
    localparam int unsigned DEF_DEPTH = 2;
    localparam int unsigned DEF_Y_W   = 1 << DEF_CW;
    localparam int unsigned CNT_W     = $clog2(DEF_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Decoded word for the default code width: 1<<code when nz, else zero.
    function automatic logic [DEF_Y_W-1:0] onehot(input logic [DEF_CW-1:0] code,
                                                  input logic              nz);
        onehot = nz ? (DEF_Y_W'(1) << code) : '0;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Small FIFO holding (code, nz) pairs.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write when push and not full
//   pop      : read when pop and not empty
//   full, empty : registered occupancy flags
//   dout     : head entry (valid when !empty)
module code_fifo #(
    parameter int unsigned W     = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] count;
    logic [OW-1:0] count_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count_d = count + OW'(do_push) - OW'(do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_d;
            full  <= (count_d == OW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage needs no reset; occupancy flags guard every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/onehot_decode_pulser.sv
// Queues (code, nz) pairs and replays each as a one-hot word held for HOLD cycles.
//   CLK, RST           : clock, asynchronous active-high reset
//   IN_VALID/IN_READY  : input handshake; IN_READY = FIFO not full
//   IN_CODE, IN_NZ     : encoded index and nonzero flag
//   OUT_Y              : decoded word (zero for nz=0 entries and when idle)
//   OUT_BUSY           : high while a word is held
//   DONE               : pulse on the last hold cycle of each word
module onehot_decode_pulser
    import decode_pkg::*;
#(
    parameter int unsigned CW    = DEF_CW,
    parameter int unsigned HOLD  = DEF_HOLD,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [CW-1:0]        IN_CODE,
    input  logic                 IN_NZ,
    output logic [(1<<CW)-1:0]   OUT_Y,
    output logic                 OUT_BUSY,
    output logic                 DONE
);

    localparam int unsigned Y_W = 1 << CW;
    localparam int unsigned HW  = $clog2(HOLD + 1);
    localparam int unsigned EW  = CW + 1;

    state_t         state, state_d;
    logic [HW-1:0]  cnt, cnt_d;
    logic [Y_W-1:0] y_d;
    logic           busy_d;
    logic           done_d;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [EW-1:0]  fifo_dout;
    logic [Y_W-1:0] head_word;

    code_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (IN_VALID),
        .pop   (pop),
        .din   ({IN_CODE, IN_NZ}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Full blocks input even when a pop happens in the same cycle.
    assign IN_READY  = !fifo_full;
    assign head_word = fifo_dout[0] ? (Y_W'(1) << fifo_dout[EW-1:1]) : '0;

    // State, hold counter and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            OUT_Y    <= '0;
            OUT_BUSY <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            OUT_Y    <= y_d;
            OUT_BUSY <= busy_d;
            DONE     <= done_d;
        end
    end

    // DONE is registered from the next count so it lands on the cycle where cnt reaches 0.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        y_d     = OUT_Y;
        busy_d  = OUT_BUSY;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                y_d    = '0;
                busy_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    y_d     = head_word;
                    cnt_d   = HW'(HOLD - 1);
                    done_d  = (HOLD == 1);
                    busy_d  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt != '0) begin
                    cnt_d  = cnt - HW'(1);
                    done_d = (cnt == HW'(1));
                end else if (!fifo_empty) begin
                    // Back-to-back reload, no idle gap between words.
                    pop    = 1'b1;
                    y_d    = head_word;
                    cnt_d  = HW'(HOLD - 1);
                    done_d = (HOLD == 1);
                end else begin
                    y_d     = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_onehot_decode_pulser.sv
module tb_onehot_decode_pulser;

    localparam int HOLD = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic [1:0] IN_CODE = 2'b00;
    logic       IN_NZ = 1'b0;
    logic       IN_READY;
    logic [3:0] OUT_Y;
    logic       OUT_BUSY;
    logic       DONE;

    onehot_decode_pulser #(.CW(2), .HOLD(HOLD), .DEPTH(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_CODE  (IN_CODE),
        .IN_NZ    (IN_NZ),
        .OUT_Y    (OUT_Y),
        .OUT_BUSY (OUT_BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_words = 0;

    typedef struct {
        logic [3:0] word;
        int         acc;
    } exp_t;
    exp_t expq[$];

    // Reference: the word a pair should produce.
    function automatic logic [3:0] model(input logic [1:0] c, input logic nz);
        logic [3:0] w;
        w = '0;
        if (nz) w[c] = 1'b1;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard input side: every accepted pair becomes an expected word.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (!RST && IN_VALID && IN_READY) begin
            expq.push_back('{model(IN_CODE, IN_NZ), cyc});
            n_acc++;
        end
    end

    // Monitor: delimits words by DONE and compares against the expected queue.
    int         run_len = 0;
    logic [3:0] run_word = '0;
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            expq.delete();
            run_len = 0;
            chk("rst_out_y", 32'(OUT_Y), 32'd0);
            chk("rst_busy", 32'(OUT_BUSY), 32'd0);
            chk("rst_done", 32'(DONE), 32'd0);
        end else if (OUT_BUSY) begin
            if (run_len == 0) begin
                run_word = OUT_Y;
                chk("word_pending", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) chk("word_not_early", 32'(expq[0].acc < cyc), 32'd1);
            end else begin
                chk("word_stable", 32'(OUT_Y), 32'(run_word));
            end
            run_len++;
            if (DONE) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("word_value", 32'(run_word), 32'(e.word));
                    n_words++;
                end
                chk("hold_len", 32'(run_len), 32'(HOLD));
                run_len = 0;
            end else if (run_len > HOLD) begin
                chk("hold_overrun", 32'(run_len), 32'(HOLD));
                run_len = 0;
            end
        end else begin
            chk("idle_out_y", 32'(OUT_Y), 32'd0);
            chk("idle_done", 32'(DONE), 32'd0);
            chk("word_cut_short", 32'(run_len), 32'd0);
            run_len = 0;
            chk("idle_with_pending", 32'(expq.size() > 0 && expq[0].acc < cyc), 32'd0);
        end
    end

    // Offer one pair from a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [1:0] c, input logic nz);
        int w;
        IN_CODE  = c;
        IN_NZ    = nz;
        IN_VALID = 1'b1;
        w = 0;
        while (!IN_READY && w < 100) begin
            @(negedge CLK);
            w++;
        end
        if (!IN_READY) chk("send_timeout", 32'(IN_READY), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((OUT_BUSY || expq.size() > 0) && w < 300) begin
            @(negedge CLK);
            #1;
            w++;
        end
        chk("drain_queue_empty", 32'(expq.size()), 32'd0);
        chk("drain_idle", 32'(OUT_BUSY), 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nd, w, seen, acc0, words0;
        logic rs;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("reset_y", 32'(OUT_Y), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", 32'(IN_READY), 32'd1);
        chk("idle_busy", 32'(OUT_BUSY), 32'd0);

        // Single word: accepted at edge t, shown after edge t+1 for HOLD cycles
        send(2'b10, 1'b1);
        chk("t2_not_yet", 32'(OUT_Y), 32'd0);
        @(negedge CLK);
        chk("t2_first", 32'(OUT_Y), 32'b0100);
        chk("t2_busy", 32'(OUT_BUSY), 32'd1);
        chk("t2_no_early_done", 32'(DONE), 32'd0);
        repeat (3) @(negedge CLK);
        chk("t2_last_done", 32'(DONE), 32'd1);
        chk("t2_last_y", 32'(OUT_Y), 32'b0100);
        @(negedge CLK);
        chk("t2_cleared", 32'(OUT_Y), 32'd0);
        chk("t2_idle", 32'(OUT_BUSY), 32'd0);
        drain();

        // Reset pulse mid-hold clears outputs immediately
        send(2'b01, 1'b1);
        repeat (2) @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("t1_rst_y", 32'(OUT_Y), 32'd0);
        chk("t1_rst_busy", 32'(OUT_BUSY), 32'd0);
        chk("t1_rst_done", 32'(DONE), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("t1_ready", 32'(IN_READY), 32'd1);
        drain();

        // Three consecutive pushes: FIFO fills, words play back-to-back
        send(2'b11, 1'b1);
        send(2'b01, 1'b1);
        send(2'b00, 1'b1);
        chk("t3_ready_drop", 32'(IN_READY), 32'd0);
        // One busy cycle has already elapsed before this point.
        nb = 0; nd = 0; w = 0;
        while (OUT_BUSY && w < 50) begin
            nb++;
            nd += int'(DONE);
            @(negedge CLK);
            w++;
        end
        chk("t3_busy_cycles", 32'(nb), 32'(3 * HOLD - 1));
        chk("t3_done_pulses", 32'(nd), 32'd3);
        drain();

        // nz=0: zero word, still busy for HOLD cycles with a DONE pulse
        send(2'b11, 1'b0);
        @(negedge CLK);
        chk("t4_busy", 32'(OUT_BUSY), 32'd1);
        chk("t4_zero", 32'(OUT_Y), 32'd0);
        drain();

        // Reset during cycle 2 of a hold with one entry queued
        send(2'b10, 1'b1);
        send(2'b01, 1'b1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_rst_y", 32'(OUT_Y), 32'd0);
        chk("t6_rst_busy", 32'(OUT_BUSY), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            seen += int'(OUT_BUSY);
        end
        chk("t6_no_replay", 32'(seen), 32'd0);
        chk("t6_ready", 32'(IN_READY), 32'd1);

        // Continuous valid with random pairs; every accepted pair must play once, in order
        acc0 = n_acc;
        words0 = n_words;
        rs = 1'b1;
        IN_VALID = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (rs) begin
                IN_CODE = 2'($urandom_range(0, 3));
                IN_NZ   = ($urandom_range(0, 3) != 0);
            end
            rs = IN_READY;
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        drain();
        chk("t5_accepted_some", 32'(n_acc - acc0 > 40), 32'd1);
        chk("t5_all_played", 32'(n_words - words0), 32'(n_acc - acc0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
